// File: rtl/uart_pkg.sv
// Shared constants for the high-speed UART path: bit timing, frame length and
// the pacing FSM state encoding.
package uart_pkg;
  localparam int BPS_CNT         = 25;
  localparam int BPS_CNT_HALF    = 12;
  localparam int UART_FRAME_CLKS = 10 * BPS_CNT + 10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  typedef logic [7:0] byte_t;
endpackage

// File: rtl/sync_fifo_byte.sv
// Byte-wide synchronous FIFO with registered read data and registered
// full/empty flags derived from an explicit occupancy count.
module sync_fifo_byte
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  byte_t                 wr_data,
  input  logic                  rd_en,
  output byte_t                 rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int                    DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_MAX = (DEPTH_LOG2+1)'(DEPTH);

  byte_t                 r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count, w_count_nxt;
  logic                  r_full, r_empty;
  byte_t                 r_rd_data;
  logic                  w_wr, w_rd;

  // Flags are the registered view, so a write in a full cycle is dropped
  // even when a pop frees a slot in that same cycle.
  assign w_wr = wr_en & ~r_full;
  assign w_rd = rd_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_rd_data <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_MAX);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign rd_data = r_rd_data;
  assign count   = r_count;
  assign full    = r_full;
  assign empty   = r_empty;
endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue plus pacing FSM for a transmitter with no busy output: one
// strobe per byte, spaced so the previous frame has always finished.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2  = 4,
  parameter int FRAME_CLKS  = UART_FRAME_CLKS,
  parameter int STROBE_CLKS = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  uart_send,
  output logic [7:0]            uart_data_out
);
  localparam logic [8:0] CNT_ONE     = 9'd1;
  localparam logic [8:0] STROBE_LAST = 9'(STROBE_CLKS - 1);
  localparam logic [8:0] FRAME_LAST  = 9'(FRAME_CLKS - 1);

  logic [1:0] r_state;
  logic [8:0] r_cnt;
  logic       r_send, r_overflow;
  logic       w_pop, w_full, w_empty;

  assign w_pop = (r_state == S_IDLE) & ~w_empty;

  // Registered read port doubles as the output data hold register: it only
  // moves on a pop, so data is stable across the whole strobe.
  sync_fifo_byte #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (uart_data_out),
    .count   (count),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_send     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en & w_full;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_STROBE;
            r_send  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_STROBE: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == STROBE_LAST) begin
            r_send  <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Leaving at FRAME_LAST keeps cnt bounded without a saturate check.
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == FRAME_LAST) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign busy      = (r_state != S_IDLE);
  assign uart_send = r_send;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboarded bench: stimulus pushes expected strobes (data, rise cycle),
// a negedge monitor pops and compares on every uart_send rising edge.
module tb_uart_tx_queue;
  localparam int DL = 4;
  localparam int FR = 260;
  localparam int SC = 2;
  localparam int SP = FR + 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full, empty, overflow, busy, uart_send;
  logic [DL:0]   count;
  logic [7:0]    uart_data_out;

  typedef struct {
    logic [7:0] data;
    int         rise;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   strobes = 0;

  uart_tx_queue #(.DEPTH_LOG2(DL), .FRAME_CLKS(FR), .STROBE_CLKS(SC)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .busy          (busy),
    .uart_send     (uart_send),
    .uart_data_out (uart_data_out)
  );

  always #10 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input int rise);
    exp_t e;
    e.data = d;
    e.rise = rise;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    sys_rst_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  // Monitor: strobe rise time, data, width and data stability.
  logic       mon_prev = 1'b0;
  int         hi_len = 0;
  logic [7:0] hi_data = 8'h00;
  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      mon_prev = 1'b0;
    end else begin
      if (uart_send && !mon_prev) begin
        strobes++;
        chk("strobe_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("strobe_data", int'(uart_data_out), int'(e.data));
          chk("strobe_rise_cycle", cyc, e.rise);
        end
        hi_len  = 1;
        hi_data = uart_data_out;
      end else if (uart_send) begin
        hi_len++;
        if (uart_data_out != hi_data)
          chk("data_stable_in_strobe", int'(uart_data_out), int'(hi_data));
      end else if (mon_prev) begin
        chk("strobe_width", hi_len, SC);
        chk("data_hold_after_strobe", int'(uart_data_out), int'(hi_data));
      end
      mon_prev = uart_send;
    end
  end

  initial begin
    int c0, ovf_n, s0;

    // Reset state
    repeat (2) tick();
    chk("rst_uart_send", int'(uart_send), 0);
    chk("rst_data_out", int'(uart_data_out), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    sys_rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_uart_send", int'(uart_send), 0);
    chk("idle_empty", int'(empty), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_count", int'(count), 0);

    // Single byte: strobe in cycles 2..3
    c0 = cyc;
    wr_en = 1'b1; wr_data = 8'hA5;
    push(8'hA5, c0 + 2);
    tick();
    wr_en = 1'b0;
    chk("single_count_c1", int'(count), 1);
    tick();
    chk("single_busy_c2", int'(busy), 1);
    chk("single_count_c2", int'(count), 0);
    wait_drain(400);

    // Three back-to-back bytes: rises 261 cycles apart
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1; wr_data = 8'(k + 1);
      push(8'(k + 1), c0 + 2 + k * SP);
      tick();
    end
    wr_en = 1'b0;
    wait_drain(1000);

    // 17 accepted writes, then 16 dropped while full
    do_reset();
    c0 = cyc;
    ovf_n = 0;
    for (int k = 0; k < 33; k++) begin
      wr_en = 1'b1; wr_data = 8'(k + 1);
      if (k < 17) push(8'(k + 1), c0 + 2 + k * SP);
      tick();
      if (overflow) ovf_n++;
      if (k == 16) begin
        chk("full_after_17", int'(full), 1);
        chk("count_after_17", int'(count), 16);
      end
    end
    wr_en = 1'b0;
    chk("overflow_pulses", ovf_n, 16);
    chk("count_held_full", int'(count), 16);

    // Write in the exact cycle of the second pop while count is 16
    while (cyc < c0 + 2 + SP - 1) tick();
    chk("pop_cycle_count", int'(count), 16);
    chk("pop_cycle_idle", int'(busy), 0);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    chk("collide_overflow", int'(overflow), 1);
    chk("collide_count", int'(count), 15);
    tick();
    chk("collide_overflow_1cyc", int'(overflow), 0);
    wait_drain(17 * SP);

    // Reset mid-WAIT with 5 bytes queued
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 7; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + k);
      if (k < 2) push(8'(8'h30 + k), c0 + 2 + k * SP);
      tick();
    end
    wr_en = 1'b0;
    while (cyc < c0 + 300) tick();
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_count", int'(count), 5);
    chk("pre_rst_sb_empty", exp_q.size(), 0);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_uart_send", int'(uart_send), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_busy", int'(busy), 0);
    exp_q.delete();
    repeat (2) tick();
    sys_rst_n = 1'b1;
    s0 = strobes;
    repeat (600) tick();
    chk("no_strobe_after_reset", strobes - s0, 0);
    chk("empty_after_reset", int'(empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
